// File: rtl/inq_ary_ctl_if.sv
// Handshake/bus bundle between the inbound-queue controller, its two requesters,
// the consumer and the 16-entry register array.
interface inq_ary_ctl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          flush;
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          wen;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data;
  logic          deq_valid;
  logic [1:0]    deq_data;
  logic          deq_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          init_done;

  // Controller side
  modport slave (
    input  flush, req0_valid, req0_data, req1_valid, req1_data, rd_data, deq_ready,
    output req0_ready, req1_ready, wen, wr_addr, wr_data, rd_addr,
           deq_valid, deq_data, count, full, empty, init_done
  );

  // Environment side: requesters, consumer and array
  modport master (
    output flush, req0_valid, req0_data, req1_valid, req1_data, rd_data, deq_ready,
    input  req0_ready, req1_ready, wen, wr_addr, wr_data, rd_addr,
           deq_valid, deq_data, count, full, empty, init_done
  );
endinterface

// File: rtl/inq_ary_ctl.sv
// Enqueue/dequeue controller for the inbound-queue register array: scrub on reset/flush,
// two-requester arbitration, circular FIFO pointers. Define INQ_CTL_RR_EN for round-robin.
module inq_ary_ctl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic         clk,
  input  logic         reset_l,
  inq_ary_ctl_if.slave bus
);

  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] SCRUB_LAST = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_scrub_cnt, w_scrub_nxt;
  logic [AW-1:0] r_wr_ptr, w_wr_nxt;
  logic [AW-1:0] r_rd_ptr, w_rd_nxt;
  logic [AW:0]   r_count, w_count_nxt;

  logic w_run, w_full, w_empty, w_can_enq;
  logic w_sel1, w_gnt0, w_gnt1, w_enq, w_deq, w_deq_valid;

  assign w_run     = (r_state == S_RUN);
  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_can_enq = w_run & ~w_full & ~bus.flush;

`ifdef INQ_CTL_RR_EN
  logic r_last_gnt, w_last_gnt_nxt;

  // On contention, favour the requester that did not win the last fire
  assign w_sel1 = bus.req1_valid & (~bus.req0_valid | ~r_last_gnt);

  always_comb begin
    w_last_gnt_nxt = r_last_gnt;
    if (w_enq) w_last_gnt_nxt = w_gnt1;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_last_gnt <= 1'b1;
    else          r_last_gnt <= w_last_gnt_nxt;
  end
`else
  assign w_sel1 = bus.req1_valid & ~bus.req0_valid;
`endif

  assign w_gnt0      = w_can_enq & bus.req0_valid & ~w_sel1;
  assign w_gnt1      = w_can_enq & w_sel1;
  assign w_enq       = w_gnt0 | w_gnt1;
  assign w_deq_valid = w_run & ~w_empty & ~bus.flush;
  assign w_deq       = w_deq_valid & bus.deq_ready;

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rd_addr    = r_rd_ptr;
  assign bus.deq_valid  = w_deq_valid;
  assign bus.deq_data   = bus.rd_data;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.init_done  = w_run;

  // Write port: scrub zeros while initialising, otherwise the granted payload
  always_comb begin
    bus.wen     = 1'b0;
    bus.wr_addr = r_wr_ptr;
    bus.wr_data = '0;
    if (!w_run) begin
      bus.wen     = 1'b1;
      bus.wr_addr = r_scrub_cnt;
    end else if (w_enq) begin
      bus.wen     = 1'b1;
      bus.wr_data = w_gnt1 ? bus.req1_data : bus.req0_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scrub_nxt = r_scrub_cnt;
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    w_count_nxt = r_count;
    if (bus.flush) begin
      w_state_nxt = S_INIT;
      w_scrub_nxt = '0;
      w_wr_nxt    = '0;
      w_rd_nxt    = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_INIT: begin
          w_scrub_nxt = r_scrub_cnt + 1'b1;
          if (r_scrub_cnt == SCRUB_LAST) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_enq) w_wr_nxt = r_wr_ptr + 1'b1;
          if (w_deq) w_rd_nxt = r_rd_ptr + 1'b1;
          case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= S_INIT;
      r_scrub_cnt <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_scrub_cnt <= w_scrub_nxt;
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_count_nxt;
    end
  end

endmodule
